// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-MOD loadable up/down counter with one-shot halt, tc pulse and load-range check.
// Optional MOD_CNT_WRAP_STAT_EN adds a saturating 16-bit wrap/halt event counter (wrap_cnt).
`default_nettype none

module mod_n_updown_counter #(
  parameter int MOD   = 38,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             done,
  output logic             load_err
`ifdef MOD_CNT_WRAP_STAT_EN
 ,output logic [15:0]      wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if ((2 ** WIDTH) < MOD) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH too small for MOD");
  end
  if (MOD < 2) begin : g_bad_mod
    $error("mod_n_updown_counter: MOD must be at least 2");
  end

  typedef enum logic [0:0] {
    COUNT = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] dout_n;
  logic             tc_n;
  logic             load_err_n;
  logic [WIDTH-1:0] term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COUNT;
      dout     <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      dout     <= dout_n;
      tc       <= tc_n;
      load_err <= load_err_n;
    end
  end

  // Terminal value depends only on the direction sampled this edge.
  assign term = up_dn ? MAX_VAL : '0;

  always_comb begin
    state_n    = state;
    dout_n     = dout;
    tc_n       = 1'b0;
    load_err_n = 1'b0;
    if (load) begin
      if (data > MAX_VAL) begin
        load_err_n = 1'b1;
      end else begin
        dout_n  = data;
        state_n = COUNT;
      end
    end else if (state == COUNT && en) begin
      if (dout == term) begin
        tc_n = 1'b1;
        if (one_shot) begin
          state_n = HALT;
        end else begin
          dout_n = up_dn ? '0 : MAX_VAL;
        end
      end else begin
        dout_n = up_dn ? (dout + ONE) : (dout - ONE);
      end
    end
  end

  assign done = (state == HALT);

`ifdef MOD_CNT_WRAP_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt <= '0;
    end else if (tc_n && (wrap_cnt != 16'hFFFF)) begin
      wrap_cnt <= wrap_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter: directed and randomized checks of mod_n_updown_counter against a behavioural model.
`default_nettype none

module tb_mod_n_updown_counter;

  localparam int MOD   = 38;
  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0, up_dn = 1'b1, one_shot = 1'b0, load = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [WIDTH-1:0] dout;
  logic             tc, done, load_err;
`ifdef MOD_CNT_WRAP_STAT_EN
  logic [15:0]      wrap_cnt;
`endif

  int checks = 0;
  int passes = 0;
  bit run    = 1'b0;

  // Behavioural model: count value, halted flag, pulses and event tally.
  int m_cnt, m_wraps;
  bit m_halt, m_tc, m_err;

  mod_n_updown_counter #(.MOD(MOD), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .one_shot(one_shot),
    .load(load), .data(data), .dout(dout), .tc(tc), .done(done),
    .load_err(load_err)
`ifdef MOD_CNT_WRAP_STAT_EN
   ,.wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_halt <= 1'b0; m_tc <= 1'b0; m_err <= 1'b0; m_wraps <= 0;
    end else begin
      m_tc  <= 1'b0;
      m_err <= 1'b0;
      if (load) begin
        if (int'(data) < MOD) begin
          m_cnt  <= int'(data);
          m_halt <= 1'b0;
        end else begin
          m_err <= 1'b1;
        end
      end else if (en && !m_halt) begin
        if (up_dn ? (m_cnt == MOD - 1) : (m_cnt == 0)) begin
          m_tc <= 1'b1;
          if (m_wraps < 65535) m_wraps <= m_wraps + 1;
          if (one_shot) m_halt <= 1'b1;
          else m_cnt <= (m_cnt + (up_dn ? 1 : MOD - 1)) % MOD;
        end else begin
          m_cnt <= (m_cnt + (up_dn ? 1 : MOD - 1)) % MOD;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model_dout", int'(dout), m_cnt);
      chk("model_tc", int'(tc), int'(m_tc));
      chk("model_done", int'(done), int'(m_halt));
      chk("model_load_err", int'(load_err), int'(m_err));
`ifdef MOD_CNT_WRAP_STAT_EN
      chk("model_wrap_cnt", int'(wrap_cnt), m_wraps);
`endif
    end
  end

  // Called at a falling edge: apply inputs, advance to the next falling edge.
  task automatic step(input logic e, input logic u, input logic o, input logic l,
                      input logic [WIDTH-1:0] d);
    en = e; up_dn = u; one_shot = o; load = l; data = d;
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", int'(dout), 0);
    chk("async_rst_tc", int'(tc), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_err", int'(load_err), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_tc", int'(tc), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(load_err), 0);
    rst = 1'b0;
    run = 1'b1;

    // Up count with wrap
    step(0, 1, 0, 1, 6'd5);
    chk("t1_load5", int'(dout), 5);
    repeat (32) step(1, 1, 0, 0, 6'd0);
    chk("t1_at37", int'(dout), 37);
    chk("t1_tc_before", int'(tc), 0);
    step(1, 1, 0, 0, 6'd0);
    chk("t1_wrap_dout", int'(dout), 0);
    chk("t1_wrap_tc", int'(tc), 1);
    chk("t1_done", int'(done), 0);
    step(1, 1, 0, 0, 6'd0);
    chk("t1_after_dout", int'(dout), 1);
    chk("t1_after_tc", int'(tc), 0);

    // Down count with wrap
    step(0, 0, 0, 1, 6'd1);
    step(1, 0, 0, 0, 6'd0);
    chk("t2_dout0", int'(dout), 0);
    step(1, 0, 0, 0, 6'd0);
    chk("t2_wrap_dout", int'(dout), 37);
    chk("t2_wrap_tc", int'(tc), 1);
    step(1, 0, 0, 0, 6'd0);
    chk("t2_dout36", int'(dout), 36);
    chk("t2_tc_low", int'(tc), 0);

    // Load range checking
    step(0, 1, 0, 1, 6'd12);
    step(1, 1, 0, 1, 6'd40);
    chk("t3_bad40_dout", int'(dout), 12);
    chk("t3_bad40_err", int'(load_err), 1);
    step(0, 1, 0, 0, 6'd0);
    chk("t3_err_clear", int'(load_err), 0);
    step(0, 1, 0, 1, 6'd38);
    chk("t3_bad38_dout", int'(dout), 12);
    chk("t3_bad38_err", int'(load_err), 1);
    step(0, 1, 0, 1, 6'd37);
    chk("t3_ok37_dout", int'(dout), 37);
    chk("t3_ok37_err", int'(load_err), 0);

    // One-shot halt and exit by load
    step(0, 1, 1, 1, 6'd35);
    step(1, 1, 1, 0, 6'd0);
    chk("t4_36", int'(dout), 36);
    step(1, 1, 1, 0, 6'd0);
    chk("t4_37", int'(dout), 37);
    chk("t4_done_pre", int'(done), 0);
    step(1, 1, 1, 0, 6'd0);
    chk("t4_halt_dout", int'(dout), 37);
    chk("t4_halt_tc", int'(tc), 1);
    chk("t4_halt_done", int'(done), 1);
    repeat (10) step(1, 1, 0, 0, 6'd0);
    chk("t4_hold_dout", int'(dout), 37);
    chk("t4_hold_tc", int'(tc), 0);
    chk("t4_hold_done", int'(done), 1);
    step(1, 1, 0, 1, 6'd10);
    chk("t4_reload_done", int'(done), 0);
    chk("t4_reload_dout", int'(dout), 10);
    step(1, 1, 0, 0, 6'd0);
    chk("t4_resume11", int'(dout), 11);
    step(1, 1, 0, 0, 6'd0);
    chk("t4_resume12", int'(dout), 12);

    // Load/enable collision at terminal, freeze, direction toggle
    step(0, 1, 0, 1, 6'd37);
    step(1, 1, 1, 1, 6'd20);
    chk("t5_collide_dout", int'(dout), 20);
    chk("t5_collide_tc", int'(tc), 0);
    chk("t5_collide_done", int'(done), 0);
    repeat (5) step(0, 1, 0, 0, 6'd0);
    chk("t5_frozen", int'(dout), 20);
    step(1, 1, 0, 0, 6'd0);
    chk("t5_up21", int'(dout), 21);
    step(1, 0, 0, 0, 6'd0);
    chk("t5_down20", int'(dout), 20);

    // Async reset mid-operation
    step(0, 1, 0, 1, 6'd17);
    chk("t6_pre", int'(dout), 17);
    en = 1'b1; load = 1'b0;
    async_reset_pulse();

`ifdef MOD_CNT_WRAP_STAT_EN
    repeat (3) begin
      step(0, 0, 0, 1, 6'd0);
      step(1, 0, 0, 0, 6'd0);
    end
    chk("t6_wrap_cnt3", int'(wrap_cnt), 3);
    step(0, 1, 0, 1, 6'd9);
    chk("t6_wrap_cnt_load", int'(wrap_cnt), 3);
    #2 rst = 1'b1;
    #1 chk("t6_wrap_cnt_rst", int'(wrap_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      load     = ($urandom_range(0, 99) < 8);
      data     = WIDTH'($urandom_range(0, 63));
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
      one_shot = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      else @(negedge clk);
    end

    run = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
